// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point execute units: rounding modes, flag
// positions, canonical NaN, operand classes and the multiplier FSM states.
package fp_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    localparam logic [31:0] CANON_NAN32 = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_INF,
        FP_QNAN,
        FP_SNAN,
        FP_NORM
    } fp_class_e;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StMul,
        StRound,
        StDone
    } fsm_state_e;

    // Exponent-zero inputs count as zero: subnormals are not supported.
    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic frac_zero, input logic frac_msb);
        if (exp_zero) begin
            return FP_ZERO;
        end else if (!exp_ones) begin
            return FP_NORM;
        end else if (frac_zero) begin
            return FP_INF;
        end else if (frac_msb) begin
            return FP_QNAN;
        end else begin
            return FP_SNAN;
        end
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round-and-pack: applies the rounding mode to a normalised significand
// with guard/round/sticky bits, then handles overflow and flush-to-zero underflow.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     sign_i,
    input  logic signed [EXP_W+1:0]  exp_i,
    input  logic [MAN_W:0]           mant_i,
    input  logic                     guard_i,
    input  logic                     round_i,
    input  logic                     sticky_i,
    input  logic [2:0]               rm_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic                     of_o,
    output logic                     uf_o,
    output logic                     nx_o
);

    localparam logic signed [EXP_W+1:0] ExpMax = {2'b00, {EXP_W{1'b1}}};

    logic                    inexact;
    logic                    round_up;
    logic [MAN_W+1:0]        mant_sum;
    logic [MAN_W:0]          mant_rnd;
    logic signed [EXP_W+1:0] exp_rnd;
    logic                    overflow;
    logic                    underflow;
    logic [EXP_W+MAN_W:0]    inf_val;
    logic [EXP_W+MAN_W:0]    max_val;

    always_comb begin
        inexact = guard_i | round_i | sticky_i;
        case (rm_i)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign_i & inexact;
            RM_RUP:  round_up = ~sign_i & inexact;
            RM_RMM:  round_up = guard_i;
            default: round_up = guard_i & (round_i | sticky_i | mant_i[0]);
        endcase

        // A carry out of the significand means it rolled over to 2.0: renormalise.
        mant_sum = {1'b0, mant_i} + {{(MAN_W + 1){1'b0}}, round_up};
        mant_rnd = mant_sum[MAN_W+1] ? mant_sum[MAN_W+1:1] : mant_sum[MAN_W:0];
        exp_rnd  = exp_i + {{(EXP_W + 1){1'b0}}, mant_sum[MAN_W+1]};

        overflow  = !exp_rnd[EXP_W+1] && (exp_rnd >= ExpMax);
        underflow = exp_rnd[EXP_W+1] || (exp_rnd == '0);

        inf_val = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        max_val = {sign_i, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

        of_o     = 1'b0;
        uf_o     = 1'b0;
        nx_o     = inexact;
        result_o = {sign_i, exp_rnd[EXP_W-1:0], mant_rnd[MAN_W-1:0]};

        if (overflow) begin
            of_o = 1'b1;
            nx_o = 1'b1;
            case (rm_i)
                RM_RTZ:  result_o = max_val;
                RM_RDN:  result_o = sign_i ? inf_val : max_val;
                RM_RUP:  result_o = sign_i ? max_val : inf_val;
                default: result_o = inf_val;
            endcase
        end else if (underflow) begin
            uf_o     = 1'b1;
            nx_o     = 1'b1;
            result_o = {sign_i, {(EXP_W + MAN_W){1'b0}}};
        end
    end

endmodule

// File: rtl/float_multiplier_mc.sv
// Multi-cycle IEEE-754 multiplier: shift-add significand product at BPC bits per cycle,
// RISC-V rounding and fflags, valid/ready on both sides.
module float_multiplier_mc
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned BPC   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [EXP_W+MAN_W:0] operand1_i,
    input  logic [EXP_W+MAN_W:0] operand2_i,
    input  logic [2:0]           rm_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [EXP_W+MAN_W:0] result_o,
    output logic [4:0]           fflags_o
);

    localparam int unsigned FpW     = 1 + EXP_W + MAN_W;
    localparam int unsigned SigW    = MAN_W + 1;
    localparam int unsigned ProdW   = 2 * SigW;
    localparam int unsigned NumIter = SigW / BPC;
    localparam int unsigned CntW    = $clog2(NumIter + 1);

    localparam logic [CntW-1:0]         LastIter = CntW'(NumIter - 1);
    localparam logic signed [EXP_W+1:0] Bias     = {3'b000, {(EXP_W - 1){1'b1}}};
    localparam logic [FpW-1:0]          CanonNan = {1'b0, {EXP_W{1'b1}}, 1'b1,
                                                    {(MAN_W - 1){1'b0}}};

    fsm_state_e              state_q, state_d;
    logic [FpW-1:0]          op1_q, op1_d;
    logic [FpW-1:0]          op2_q, op2_d;
    logic [2:0]              rm_q, rm_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W+1:0] exp_q, exp_d;
    logic [SigW-1:0]         mcand_q, mcand_d;
    logic [SigW-1:0]         mplier_q, mplier_d;
    logic [ProdW-1:0]        acc_q, acc_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [FpW-1:0]          result_q, result_d;
    logic [4:0]              fflags_q, fflags_d;

    logic [EXP_W-1:0] exp1, exp2;
    logic [MAN_W-1:0] frac1, frac2;
    fp_class_e        cls1, cls2;

    assign exp1  = op1_q[FpW-2:MAN_W];
    assign exp2  = op2_q[FpW-2:MAN_W];
    assign frac1 = op1_q[MAN_W-1:0];
    assign frac2 = op2_q[MAN_W-1:0];
    assign cls1  = classify(exp1 == '0, &exp1, frac1 == '0, frac1[MAN_W-1]);
    assign cls2  = classify(exp2 == '0, &exp2, frac2 == '0, frac2[MAN_W-1]);

    logic any_nan, any_snan, inf_times_zero, any_inf, any_zero;

    assign any_nan        = (cls1 == FP_QNAN) || (cls1 == FP_SNAN) ||
                            (cls2 == FP_QNAN) || (cls2 == FP_SNAN);
    assign any_snan       = (cls1 == FP_SNAN) || (cls2 == FP_SNAN);
    assign inf_times_zero = ((cls1 == FP_INF) && (cls2 == FP_ZERO)) ||
                            ((cls1 == FP_ZERO) && (cls2 == FP_INF));
    assign any_inf        = (cls1 == FP_INF) || (cls2 == FP_INF);
    assign any_zero       = (cls1 == FP_ZERO) || (cls2 == FP_ZERO);

    // Accumulator shifts right as multiplier digits are consumed LSB first, so each
    // partial product always lands at the same offset.
    logic [SigW+BPC-1:0] partial;

    assign partial = {{BPC{1'b0}}, mcand_q} * {{SigW{1'b0}}, mplier_q[BPC-1:0]};

    logic [ProdW-1:0]        prod_norm;
    logic signed [EXP_W+1:0] exp_norm;
    logic [FpW-1:0]          rp_result;
    logic                    rp_of, rp_uf, rp_nx;

    assign prod_norm = acc_q[ProdW-1] ? acc_q : (acc_q << 1);
    assign exp_norm  = exp_q + {{(EXP_W + 1){1'b0}}, acc_q[ProdW-1]};

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign_i   (sign_q),
        .exp_i    (exp_norm),
        .mant_i   (prod_norm[ProdW-1 -: SigW]),
        .guard_i  (prod_norm[ProdW-1-SigW]),
        .round_i  (prod_norm[ProdW-2-SigW]),
        .sticky_i (|prod_norm[ProdW-3-SigW:0]),
        .rm_i     (rm_q),
        .result_o (rp_result),
        .of_o     (rp_of),
        .uf_o     (rp_uf),
        .nx_o     (rp_nx)
    );

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        rm_d     = rm_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        fflags_d = fflags_q;

        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    op1_d   = operand1_i;
                    op2_d   = operand2_i;
                    rm_d    = rm_i;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                sign_d = op1_q[FpW-1] ^ op2_q[FpW-1];
                if (any_nan || inf_times_zero) begin
                    result_d          = CanonNan;
                    fflags_d          = '0;
                    fflags_d[FLAG_NV] = any_snan || inf_times_zero;
                    state_d           = StDone;
                end else if (any_inf) begin
                    result_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    fflags_d = '0;
                    state_d  = StDone;
                end else if (any_zero) begin
                    result_d = {sign_d, {(EXP_W + MAN_W){1'b0}}};
                    fflags_d = '0;
                    state_d  = StDone;
                end else begin
                    exp_d    = $signed({2'b00, exp1}) + $signed({2'b00, exp2}) - Bias;
                    mcand_d  = {1'b1, frac1};
                    mplier_d = {1'b1, frac2};
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StMul;
                end
            end
            StMul: begin
                acc_d    = (acc_q >> BPC) + (ProdW'(partial) << (SigW - BPC));
                mplier_d = mplier_q >> BPC;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                result_d          = rp_result;
                fflags_d          = '0;
                fflags_d[FLAG_OF] = rp_of;
                fflags_d[FLAG_UF] = rp_uf;
                fflags_d[FLAG_NX] = rp_nx;
                state_d           = StDone;
            end
            StDone: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // An aborted operation must leave the visible result untouched.
        if (flush_i) begin
            state_d  = StIdle;
            result_d = result_q;
            fflags_d = fflags_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            op1_q    <= '0;
            op2_q    <= '0;
            rm_q     <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            fflags_q <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rm_q     <= rm_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            fflags_q <= fflags_d;
        end
    end

    assign ready_o  = (state_q == StIdle);
    assign valid_o  = (state_q == StDone);
    assign result_o = result_q;
    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_float_multiplier_mc.sv
// Scoreboard bench for float_multiplier_mc: directed and random operands, expected
// results from an integer-arithmetic reference model, checked by a separate monitor.
module tb_float_multiplier_mc;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] operand1_i = '0;
    logic [31:0] operand2_i = '0;
    logic [2:0]  rm_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;

    float_multiplier_mc dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .rm_i       (rm_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .fflags_o   (fflags_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   rand_ready = 1'b0;
    bit   force_ready = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer significand product, rounded by remainder comparison.
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] rm, output logic [31:0] res,
                                    output logic [4:0] fl, output int lat);
        bit s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, inexact, up;
        int ea, eb, e, sh;
        longint unsigned p, q, rem, half;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        fl     = 5'h00;
        lat    = 2;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            res = 32'h7FC0_0000;
            if (a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf)) fl = 5'h10;
        end else if (a_inf || b_inf) begin
            res = {s, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            res = {s, 31'h0};
        end else begin
            lat = 9;
            p = ({41'd1, a[22:0]} | 64'h0) * ({41'd1, b[22:0]} | 64'h0);
            e = ea + eb - 127;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end else begin
                sh = 23;
            end
            q       = p >> sh;
            rem     = p - (q << sh);
            half    = 64'd1 << (sh - 1);
            inexact = (rem != 0);
            case (rm)
                3'd1:    up = 1'b0;
                3'd2:    up = s && inexact;
                3'd3:    up = !s && inexact;
                3'd4:    up = (rem >= half);
                default: up = (rem > half) || ((rem == half) && q[0]);
            endcase
            q = q + 64'(up);
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                fl = 5'h05;
                case (rm)
                    3'd1:    res = {s, 31'h7F7F_FFFF};
                    3'd2:    res = s ? {s, 31'h7F80_0000} : {s, 31'h7F7F_FFFF};
                    3'd3:    res = s ? {s, 31'h7F7F_FFFF} : {s, 31'h7F80_0000};
                    default: res = {s, 31'h7F80_0000};
                endcase
            end else if (e <= 0) begin
                fl  = 5'h03;
                res = {s, 31'h0};
            end else begin
                fl  = {4'h0, inexact};
                res = {s, 8'(e), 23'(q)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        k = $urandom_range(0, 13);
        case (k)
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7F80_0000;
            3:       return 32'hFF80_0000;
            4:       return 32'h7FC0_0000;
            5:       return {1'($urandom), 8'hFF, 1'b0, 22'($urandom) | 22'h1};
            6:       return {1'($urandom), 8'h00, 23'($urandom)};
            7, 8:    return {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
            9, 10:   return {1'($urandom), 8'($urandom_range(1, 60)), 23'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         output int c0, output bit ok);
        int waited;
        waited = 0;
        while (!ready_o && waited < 100) begin
            @(posedge clk_i);
            #1;
            waited++;
        end
        c0 = cyc;
        ok = ready_o;
        if (!ok) begin
            n_fail++;
            $display("FAIL issue_timeout ready_o=%0b required=1", ready_o);
            return;
        end
        operand1_i = a;
        operand2_i = b;
        rm_i       = rm;
        valid_i    = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic send_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                            input logic [31:0] er, input logic [4:0] ef, input int el);
        int  c0;
        bit  ok;
        issue(a, b, rm, c0, ok);
        if (ok) sb.push_back('{res: er, fl: ef, lat: el, acc_cyc: c0});
    endtask

    task automatic send_rand(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        logic [31:0] r;
        logic [4:0]  f;
        int          l;
        ref_mul(a, b, rm, r, f, l);
        send_exp(a, b, rm, r, f, l);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            ready_i = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
        end
    end

    // Monitor: compares the head of the scoreboard every cycle the result is presented.
    initial begin
        exp_t cur;
        bit   valid_prev;
        bit   chk_rdy;
        valid_prev = 1'b0;
        chk_rdy    = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                valid_prev = 1'b0;
                chk_rdy    = 1'b0;
            end else begin
                if (chk_rdy) begin
                    chk_rdy = 1'b0;
                    check("ready_after_handshake", 32'(ready_o), 32'd1);
                end
                if (valid_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 32'(valid_o), 32'd0);
                    end else begin
                        cur = sb[0];
                        if (!valid_prev) check("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
                        check("result", result_o, cur.res);
                        check("fflags", 32'(fflags_o), 32'(cur.fl));
                        if (ready_i) begin
                            void'(sb.pop_front());
                            n_vec++;
                            chk_rdy = 1'b1;
                        end
                    end
                end
                valid_prev = valid_o;
            end
        end
    end

    initial begin
        int  c0;
        bit  ok;
        int  t;
        logic [31:0] a, b;

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_result", result_o, 32'h0);
        check("reset_fflags", 32'(fflags_o), 32'h0);
        rst_i = 1'b0;

        send_exp(32'h4000_0000, 32'h4040_0000, 3'd0, 32'h40C0_0000, 5'h00, 9);
        send_exp(32'h3F80_0001, 32'h3F80_0001, 3'd0, 32'h3F80_0002, 5'h01, 9);
        send_exp(32'h3F80_0001, 32'h3F80_0001, 3'd3, 32'h3F80_0003, 5'h01, 9);
        send_exp(32'h3F80_0001, 32'h3F80_0001, 3'd1, 32'h3F80_0002, 5'h01, 9);
        send_exp(32'h7F00_0000, 32'h7F00_0000, 3'd0, 32'h7F80_0000, 5'h05, 9);
        send_exp(32'h7F00_0000, 32'h7F00_0000, 3'd1, 32'h7F7F_FFFF, 5'h05, 9);
        send_exp(32'hFF00_0000, 32'h7F00_0000, 3'd3, 32'hFF7F_FFFF, 5'h05, 9);
        send_exp(32'hFF00_0000, 32'h7F00_0000, 3'd2, 32'hFF80_0000, 5'h05, 9);
        send_exp(32'h7F80_0000, 32'h0000_0000, 3'd0, 32'h7FC0_0000, 5'h10, 2);
        send_exp(32'h7FA0_0000, 32'h3F80_0000, 3'd0, 32'h7FC0_0000, 5'h10, 2);
        send_exp(32'h7FC0_0000, 32'h3F80_0000, 3'd0, 32'h7FC0_0000, 5'h00, 2);
        send_exp(32'h8000_0000, 32'h4000_0000, 3'd0, 32'h8000_0000, 5'h00, 2);
        send_exp(32'h0080_0000, 32'h3F00_0000, 3'd0, 32'h0000_0000, 5'h03, 9);
        send_exp(32'h3F80_0003, 32'h3FC0_0000, 3'd0, 32'h3FC0_0004, 5'h01, 9);
        send_exp(32'h3F80_0003, 32'h3FC0_0000, 3'd4, 32'h3FC0_0005, 5'h01, 9);
        send_exp(32'h3F80_0003, 32'h3FC0_0000, 3'd6, 32'h3FC0_0004, 5'h01, 9);
        drain();

        // Back-pressure: result must stay presented while ready_i is low.
        force_ready = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        send_exp(32'h4000_0000, 32'h4040_0000, 3'd0, 32'h40C0_0000, 5'h00, 9);
        t = 0;
        while (!valid_o && t < 50) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        check("hold_valid_rise", 32'(valid_o), 32'd1);
        repeat (5) begin
            @(posedge clk_i);
            #1;
            check("hold_valid_stays", 32'(valid_o), 32'd1);
        end
        force_ready = 1'b1;
        drain();

        // Flush during the third multiply cycle: no result may appear.
        issue(32'h4000_0000, 32'h4080_0000, 3'd0, c0, ok);
        repeat (3) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_ready", 32'(ready_o), 32'd1);
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_keeps_result", result_o, 32'h40C0_0000);
        repeat (12) @(posedge clk_i);
        #1;
        send_exp(32'h4040_0000, 32'h4040_0000, 3'd0, 32'h4110_0000, 5'h00, 9);
        drain();

        // Reset in the middle of a multiply.
        issue(32'h4000_0000, 32'h4080_0000, 3'd0, c0, ok);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("midrst_ready", 32'(ready_o), 32'd1);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_result", result_o, 32'h0);
        check("midrst_fflags", 32'(fflags_o), 32'h0);
        repeat (12) @(posedge clk_i);
        #1;

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = rand_op();
            b = rand_op();
            send_rand(a, b, 3'($urandom_range(0, 7)));
        end
        drain();
        rand_ready = 1'b0;

        repeat (3) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/float_multiplier_mc.md
Name: float_multiplier_mc

Overview:
Parametrised, multi-cycle IEEE-754 binary floating-point multiplier for the execute stage.
- Operands are accepted through a valid/ready handshake.
- The significand product is formed iteratively, BPC bits per cycle.
- The result is normalised and rounded per RISC-V rounding mode, then returned with RISC-V fflags.
- Issue logic connects to the input side; the writeback arbiter drains the output side.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (FP_W = 1+EXP_W+MAN_W, 32 by default)
BPC, 4, multiplier bits retired per cycle; must divide MAN_W+1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  abort any operation in flight, return to IDLE
valid_i  in  1  operands/rm valid
ready_o  out  1  unit can accept (high only in IDLE)
operand1_i  in  FP_W  multiplicand
operand2_i  in  FP_W  multiplier
rm_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
result_o  out  FP_W  product
fflags_o  out  5  {NV,DZ,OF,UF,NX}; DZ always 0

Behaviour:
Reset state (rst_i high on a rising clk_i edge):
- State is IDLE; ready_o=1, valid_o=0.
- result_o=0 and fflags_o=0.
- Reset applies even mid-operation.

FSM states: IDLE, UNPACK, MUL, ROUND, DONE.
- IDLE: on valid_i&&ready_o, latch operands and rm. Go to UNPACK.
- UNPACK:
  - Split sign, exponent and fraction; prepend the hidden 1.
  - Inputs with exponent field 0 are treated as zero (denormals-are-zero).
  - Classify each operand as zero, inf, qNaN, sNaN or normal.
  - If either is special, form the result directly and go to DONE.
  - Otherwise set exponent sum = e1+e2-bias (signed, EXP_W+2 bits), clear the accumulator and go to MUL.
- MUL:
  - Shift-add BPC multiplier bits per cycle into a 2*(MAN_W+1)-bit accumulator.
  - Run for (MAN_W+1)/BPC cycles (6 by default), then go to ROUND.
- ROUND:
  - If product bit[2*MAN_W+1] is set, shift right 1 and increment the exponent.
  - Take guard and round bits plus a sticky OR of the remaining bits; apply rm.
  - A mantissa carry-out renormalises the result and increments the exponent.
  - Apply overflow and underflow rules below, then go to DONE.
- DONE:
  - valid_o=1; result_o and fflags_o held stable until ready_i.
  - On ready_i, go to IDLE. ready_o rises the cycle after the handshake; no back-to-back accept.

Latency, valid_i accepted to valid_o rising:
- Normal path: 1+(MAN_W+1)/BPC+1+1 cycles (9 by default).
- Special path: 2 cycles.

Special cases:
- Any NaN, or inf*0: canonical qNaN (0x7FC00000), sign 0.
  - NV=1 for inf*0 or any sNaN input.
  - quiet NaN inputs alone give NV=0.
- inf*finite-nonzero or inf*inf: inf with sign XOR, no flags.
- zero*finite: zero with sign XOR, no flags.

Overflow (rounded exponent ≥ 2^EXP_W-1): OF=1, NX=1.
- RNE/RMM give inf.
- RTZ gives max finite.
- RDN gives max finite if positive, -inf if negative.
- RUP gives +inf if positive, -max finite if negative.

Underflow (rounded exponent ≤ 0): flush to signed zero, UF=1, NX=1 (flush-to-zero; no subnormal outputs).

NX=1 whenever any of guard, round or sticky is nonzero.

flush_i:
- Any state goes to IDLE next cycle; valid_o=0 and outputs are not updated.
- flush_i has priority over ready_i in DONE.
- rst_i has priority over flush_i.

Decomposition:
Shared package fp_pkg holds:
- rm encodings (RM_RNE..RM_RMM) and fflags bit indices.
- Canonical NaN constant.
- Operand class enum (FP_ZERO, FP_INF, FP_QNAN, FP_SNAN, FP_NORM).
- FSM state typedef.

One natural sub-module: fp_round_pack. It is combinational and takes sign, exponent, normalised mantissa, GRS bits and rm. It produces the packed result, OF, UF and NX, and is reused by future fadd/fdiv units.

Test Plan:
- 0x40000000*0x40400000, RNE, ready_i=1 → valid_o at cycle 9 after accept, result 0x40C00000, fflags 0x00; ready_o back high the cycle after the handshake.
- 0x3F800001*0x3F800001: RNE → 0x3F800002, fflags 0x01; RUP → 0x3F800003, fflags 0x01; RTZ → 0x3F800002.
- 0x7F000000*0x7F000000: RNE → 0x7F800000, fflags 0x05; RTZ → 0x7F7FFFFF, fflags 0x05. With sign-flipped operand1 (0xFF000000): RUP → 0xFF7FFFFF.
- Special cases, each with 2-cycle latency:
  - 0x7F800000*0x00000000 → 0x7FC00000, fflags 0x10.
  - 0x7FA00000 (sNaN)*0x3F800000 → 0x7FC00000, fflags 0x10.
  - 0x7FC00000*0x3F800000 → 0x7FC00000, fflags 0x00.
  - 0x80000000*0x40000000 → 0x80000000, fflags 0x00.
- 0x00800000*0x3F000000, RNE → 0x00000000, fflags 0x03.
- Control:
  - Hold ready_i=0 for 5 cycles in DONE → result_o stable and valid_o stays high.
  - Assert flush_i at MUL cycle 3 → valid_o never rises; ready_o=1 next cycle; a new op then completes correctly.
  - Assert rst_i mid-MUL → all outputs at reset values next cycle.
